// File: rtl/coin_accumulator.sv
// Vending front-end credit stage: accepts coins, latches a product selection
// and holds a money/product request for the dispense core; cancel/timeout refund locally.
module coin_accumulator #(
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int HOLD_CYCLES    = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       coin_valid,
   input  logic [1:0] coin_type,
   input  logic [1:0] sel,
   input  logic       cancel,
   output logic [3:0] money,
   output logic [1:0] ps,
   output logic       vend_req,
   output logic       coin_reject,
   output logic       refund_valid,
   output logic [3:0] refund_amt,
   output logic [3:0] credit,
   output logic       busy
);

   localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [HW-1:0] HMAX = HW'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, COLLECT, DISPATCH} state_t;

   state_t        state;
   logic [TW-1:0] timer;
   logic [HW-1:0] hold;

   logic [3:0] value;
   logic [4:0] sum;
   logic       accept;
   logic       sel_ok;
   logic [3:0] next_credit;

   // Overflow is judged on a 5-bit sum so 13+5 cannot wrap into range.
   always_comb begin
      value = 4'd0;
      unique case (coin_type)
         2'b00: value = 4'd1;
         2'b01: value = 4'd2;
         2'b10: value = 4'd5;
         2'b11: value = 4'd0;
      endcase
      sum         = {1'b0, credit} + {1'b0, value};
      accept      = coin_valid && (coin_type != 2'b11) &&
                    (sum <= 5'd15) && (state != DISPATCH);
      sel_ok      = (sel == 2'b10) || (sel == 2'b01);
      next_credit = accept ? sum[3:0] : credit;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         credit       <= 4'd0;
         money        <= 4'd0;
         ps           <= 2'b00;
         vend_req     <= 1'b0;
         coin_reject  <= 1'b0;
         refund_valid <= 1'b0;
         refund_amt   <= 4'd0;
         busy         <= 1'b0;
         timer        <= '0;
         hold         <= '0;
      end else begin
         coin_reject  <= coin_valid && !accept;
         refund_valid <= 1'b0;
         refund_amt   <= 4'd0;
         unique case (state)
            IDLE: begin
               if (accept) begin
                  credit <= next_credit;
                  timer  <= '0;
                  state  <= COLLECT;
               end
            end
            COLLECT: begin
               credit <= next_credit;
               if (cancel || (!coin_valid && !sel_ok && timer == TMAX)) begin
                  refund_valid <= 1'b1;
                  refund_amt   <= next_credit;
                  credit       <= 4'd0;
                  timer        <= '0;
                  state        <= IDLE;
               end else if (sel_ok) begin
                  ps       <= sel;
                  money    <= next_credit;
                  vend_req <= 1'b1;
                  busy     <= 1'b1;
                  hold     <= '0;
                  state    <= DISPATCH;
               end else if (coin_valid) begin
                  timer <= '0;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            DISPATCH: begin
               if (hold == HMAX) begin
                  credit   <= 4'd0;
                  money    <= 4'd0;
                  ps       <= 2'b00;
                  vend_req <= 1'b0;
                  busy     <= 1'b0;
                  state    <= IDLE;
               end else begin
                  hold <= hold + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_coin_accumulator.sv
// Scoreboard bench for coin_accumulator: stimulus queues expected events,
// a negedge monitor pops and compares them as the DUT emits them.
module tb_coin_accumulator;

   logic       clk = 1'b0;
   logic       reset;
   logic       coin_valid;
   logic [1:0] coin_type;
   logic [1:0] sel;
   logic       cancel;
   logic [3:0] money;
   logic [1:0] ps;
   logic       vend_req;
   logic       coin_reject;
   logic       refund_valid;
   logic [3:0] refund_amt;
   logic [3:0] credit;
   logic       busy;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0] m;
      logic [1:0] p;
      int         len;
   } vend_t;

   vend_t      vend_q[$];
   logic [3:0] rej_q[$];
   logic [3:0] ref_q[$];

   coin_accumulator #(.TIMEOUT_CYCLES(8), .HOLD_CYCLES(2)) dut (
      .clk(clk), .reset(reset), .coin_valid(coin_valid),
      .coin_type(coin_type), .sel(sel), .cancel(cancel),
      .money(money), .ps(ps), .vend_req(vend_req),
      .coin_reject(coin_reject), .refund_valid(refund_valid),
      .refund_amt(refund_amt), .credit(credit), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", n, a, e);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic coin(input logic [1:0] t);
      coin_valid = 1'b1;
      coin_type  = t;
      tick();
      coin_valid = 1'b0;
   endtask

   // monitor
   logic       prev_v = 1'b0;
   int         run = 0;
   vend_t      cur;

   always @(negedge clk) begin
      if (coin_reject === 1'b1) begin
         if (rej_q.size() == 0) chk("unexpected_reject", 1, 0);
         else chk("reject_credit", credit, rej_q.pop_front());
      end
      if (refund_valid === 1'b1) begin
         if (ref_q.size() == 0) chk("unexpected_refund", 1, 0);
         else chk("refund_amt", refund_amt, ref_q.pop_front());
      end
      if (vend_req === 1'b1 && !prev_v) begin
         run = 1;
         if (vend_q.size() == 0) begin
            chk("unexpected_vend", 1, 0);
            cur = '{money, ps, 0};
         end else begin
            cur = vend_q.pop_front();
            chk("vend_money", money, cur.m);
            chk("vend_ps", ps, cur.p);
         end
      end else if (vend_req === 1'b1) begin
         run++;
         chk("vend_stable", {money, ps}, {cur.m, cur.p});
      end else if (prev_v) begin
         chk("vend_len", run, cur.len);
      end
      prev_v = (vend_req === 1'b1);
   end

   initial begin
      reset = 1'b1; coin_valid = 1'b0; coin_type = 2'b00;
      sel = 2'b00; cancel = 1'b0;
      tick(); tick();
      chk("rst_credit", credit, 0);
      chk("rst_money", money, 0);
      chk("rst_ps", ps, 0);
      chk("rst_vend", vend_req, 0);
      chk("rst_busy", busy, 0);
      chk("rst_refund", {refund_valid, refund_amt}, 0);
      chk("rst_reject", coin_reject, 0);
      reset = 1'b0;
      tick();

      // 5 + 5 then product A
      coin(2'b10); tick(); coin(2'b10);
      chk("credit_10", credit, 10);
      tick();
      vend_q.push_back('{4'd10, 2'b10, 2});
      sel = 2'b10; tick(); sel = 2'b00;
      chk("vend_c1", vend_req, 1);
      chk("busy_c1", busy, 1);
      tick();
      chk("vend_c2", vend_req, 1);
      tick();
      chk("vend_done", vend_req, 0);
      chk("credit_clr", credit, 0);
      chk("busy_clr", busy, 0);

      // overflow and invalid coin rejection
      coin(2'b10); coin(2'b10); coin(2'b01); coin(2'b00);
      chk("credit_13", credit, 13);
      rej_q.push_back(4'd13); coin(2'b10);
      chk("credit_13_hold", credit, 13);
      coin(2'b01);
      chk("credit_15", credit, 15);
      rej_q.push_back(4'd15); coin(2'b00);
      chk("credit_15_hold", credit, 15);
      rej_q.push_back(4'd15); coin(2'b11);
      chk("credit_bad_type", credit, 15);
      ref_q.push_back(4'd15);
      cancel = 1'b1; tick(); cancel = 1'b0;
      chk("cancel_refund", refund_valid, 1);
      chk("cancel_credit", credit, 0);

      // coin during dispatch
      coin(2'b10);
      vend_q.push_back('{4'd5, 2'b01, 2});
      sel = 2'b01; tick(); sel = 2'b00;
      rej_q.push_back(4'd5); coin(2'b00);
      chk("disp_money", money, 5);
      tick();
      chk("disp_end_vend", vend_req, 0);
      chk("disp_end_credit", credit, 0);

      // cancel beats sel
      coin(2'b10); coin(2'b01);
      ref_q.push_back(4'd7);
      cancel = 1'b1; sel = 2'b01; tick(); cancel = 1'b0; sel = 2'b00;
      chk("cxl_sel_amt", refund_amt, 7);
      chk("cxl_sel_vend", vend_req, 0);
      chk("cxl_sel_credit", credit, 0);

      // timeout after exactly 8 idle cycles
      coin(2'b01); coin(2'b00);
      chk("credit_3", credit, 3);
      ref_q.push_back(4'd3);
      repeat (7) tick();
      chk("to_early", refund_valid, 0);
      tick();
      chk("to_fire", refund_valid, 1);
      chk("to_credit", credit, 0);

      // coin at idle cycle 5 restarts the count
      coin(2'b00); coin(2'b01);
      repeat (4) tick();
      coin(2'b01);
      chk("credit_5", credit, 5);
      repeat (7) tick();
      chk("to_restart_early", refund_valid, 0);
      ref_q.push_back(4'd5);
      tick();
      chk("to_restart_fire", refund_valid, 1);

      // coin with sel, then reset in first dispatch cycle
      coin(2'b10); coin(2'b10); coin(2'b01);
      chk("credit_12", credit, 12);
      vend_q.push_back('{4'd14, 2'b10, 1});
      coin_valid = 1'b1; coin_type = 2'b01; sel = 2'b10;
      tick();
      coin_valid = 1'b0; sel = 2'b00;
      chk("coin_sel_money", money, 14);
      reset = 1'b1; tick(); reset = 1'b0;
      chk("mid_rst_vend", vend_req, 0);
      chk("mid_rst_outs", {money, ps, credit, busy, refund_valid, coin_reject}, 0);
      repeat (3) tick();

      chk("vend_q_empty", vend_q.size(), 0);
      chk("rej_q_empty", rej_q.size(), 0);
      chk("ref_q_empty", ref_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
